// File: rtl/bcd_time_keeper_if.sv
// Button inputs, run enable and time/display outputs of the time-of-day core.
interface bcd_time_keeper_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       run_en;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    modport master (
        output btn_mode, btn_inc, run_en,
        input  hour_bcd, min_bcd, sec_bcd, mode, blink, sec_pulse
    );

    modport slave (
        input  btn_mode, btn_inc, run_en,
        output hour_bcd, min_bcd, sec_bcd, mode, blink, sec_pulse
    );
endinterface

// File: rtl/bcd_time_keeper.sv
// Time-of-day core: 1 Hz prescaler, packed-BCD HH:MM:SS, two debounced
// set buttons and a blink phase for the field being edited.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RUN      | time advances on sec_pulse when run_en is high
// ST_SET_HOUR | inc press bumps hours (23 -> 00), seconds frozen
// ST_SET_MIN  | inc press bumps minutes (59 -> 00), seconds frozen
module bcd_time_keeper #(
    parameter int PRESCALE        = 65536,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    bcd_time_keeper_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(PRESCALE / 2);
    localparam logic [DW-1:0] DB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            presc_clr;
    logic            sec_pulse_q, blink_q;

    // Button index 0 is mode, index 1 is inc.
    logic [1:0]      btn_raw, sync_a, sync_b, level, press;
    logic [DW-1:0]   db_cnt [2];
    logic            mode_ev, inc_ev;

    assign btn_raw = {bus.btn_inc, bus.btn_mode};
    assign mode_ev = press[0];
    assign inc_ev  = press[1];

    // Wrapping BCD increment; tens and units roll independently until max.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Synchronize each button and accept a new level after a full down-count of
    // stable disagreeing samples; only a 0->1 acceptance produces a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            level  <= '0;
            press  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= DB_LOAD;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= DB_LOAD;
                end else if (db_cnt[i] == '0) begin
                    level[i]  <= sync_b[i];
                    press[i]  <= sync_b[i];
                    db_cnt[i] <= DB_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Next mode, time fields and prescaler; mode presses take priority over inc.
    always_comb begin
        state_d   = state_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        presc_clr = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_ev) state_d = ST_SET_HOUR;
                if (sec_pulse_q && bus.run_en) begin
                    sec_d = bcd_next(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_next(min_q, 8'h59);
                        if (min_q == 8'h59) hour_d = bcd_next(hour_q, 8'h23);
                    end
                end
            end
            ST_SET_HOUR: begin
                if (mode_ev)     state_d = ST_SET_MIN;
                else if (inc_ev) hour_d  = bcd_next(hour_q, 8'h23);
            end
            ST_SET_MIN: begin
                if (mode_ev) begin
                    // Restart the second cleanly so the new time starts on a boundary.
                    state_d   = ST_RUN;
                    sec_d     = 8'h00;
                    presc_clr = 1'b1;
                end else if (inc_ev) begin
                    min_d = bcd_next(min_q, 8'h59);
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (presc_clr || presc_q == PRESC_LAST) presc_d = '0;
        else                                    presc_d = presc_q + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Time, prescaler and registered display outputs; sec_pulse tracks presc == last.
    always_ff @(posedge clock) begin
        if (reset) begin
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            presc_q     <= '0;
            sec_pulse_q <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            sec_pulse_q <= (presc_d == PRESC_LAST);
            blink_q     <= (state_d == ST_RUN) ? 1'b1 : (presc_d < PRESC_HALF);
        end
    end

    assign bus.hour_bcd  = hour_q;
    assign bus.min_bcd   = min_q;
    assign bus.sec_bcd   = sec_q;
    assign bus.mode      = state_q;
    assign bus.blink     = blink_q;
    assign bus.sec_pulse = sec_pulse_q;
endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper with PRESCALE=8, DEBOUNCE_CYCLES=4.
module tb_bcd_time_keeper;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    bcd_time_keeper_if bus();

    bcd_time_keeper #(.PRESCALE(8), .DEBOUNCE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // which: 0 = mode, 1 = inc
    task automatic press_btn(input bit which, input int hold);
        if (which) bus.btn_inc = 1'b1; else bus.btn_mode = 1'b1;
        tick(hold);
        bus.btn_inc  = 1'b0;
        bus.btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.run_en   = 1'b0;
        apply_reset();
        vectors++; if (bus.hour_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_hour got %h want 00", bus.hour_bcd); end
        vectors++; if (bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_min got %h want 00", bus.min_bcd); end
        vectors++; if (bus.sec_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_sec got %h want 00", bus.sec_bcd); end
        vectors++; if (bus.mode !== 2'b00) begin miscompares++; $display("FAIL reset_mode got %b want 00", bus.mode); end
        vectors++; if (bus.blink !== 1'b1) begin miscompares++; $display("FAIL reset_blink got %b want 1", bus.blink); end
        vectors++; if (bus.sec_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_sec_pulse got %b want 0", bus.sec_pulse); end
    endtask

    task automatic test_run_minute();
        int pulses = 0;
        int blink_low = 0;
        apply_reset();
        bus.run_en = 1'b1;
        for (int i = 1; i <= 480; i++) begin
            tick(1);
            if (bus.sec_pulse === 1'b1) pulses++;
            if (bus.blink !== 1'b1) blink_low++;
            if (i == 200) begin
                vectors++; if (bus.sec_bcd !== 8'h25) begin miscompares++; $display("FAIL run_sec_200 got %h want 25", bus.sec_bcd); end
            end
            if (i == 472) begin
                vectors++; if (bus.sec_bcd !== 8'h59 || bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL run_sec_59 got %h:%h want 00:59", bus.min_bcd, bus.sec_bcd); end
            end
        end
        vectors++; if (bus.sec_bcd !== 8'h00) begin miscompares++; $display("FAIL run_sec_wrap got %h want 00", bus.sec_bcd); end
        vectors++; if (bus.min_bcd !== 8'h01) begin miscompares++; $display("FAIL run_min_carry got %h want 01", bus.min_bcd); end
        vectors++; if (bus.hour_bcd !== 8'h00) begin miscompares++; $display("FAIL run_hour got %h want 00", bus.hour_bcd); end
        vectors++; if (pulses !== 60) begin miscompares++; $display("FAIL run_pulse_count got %0d want 60", pulses); end
        vectors++; if (blink_low !== 0) begin miscompares++; $display("FAIL run_blink_low got %0d want 0", blink_low); end
        bus.run_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (bus.sec_pulse === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL hold_pulse_count got %0d want 2", pulses); end
        vectors++; if (bus.sec_bcd !== 8'h00 || bus.min_bcd !== 8'h01) begin miscompares++; $display("FAIL hold_frozen got %h:%h want 01:00", bus.min_bcd, bus.sec_bcd); end
    endtask

    task automatic test_debounce_mode();
        int changes = 0;
        logic [1:0] prev;
        bit found = 1'b0;
        apply_reset();
        bus.run_en = 1'b1;
        tick(40);
        vectors++; if (bus.sec_bcd !== 8'h05) begin miscompares++; $display("FAIL pre_sec got %h want 05", bus.sec_bcd); end
        bus.run_en = 1'b0;
        press_btn(1'b0, 3);
        tick(10);
        vectors++; if (bus.mode !== 2'b00) begin miscompares++; $display("FAIL short_press_mode got %b want 00", bus.mode); end
        bus.btn_mode = 1'b1;
        prev = bus.mode;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i == 10) bus.btn_mode = 1'b0;
            if (i == 6) begin
                vectors++; if (bus.mode !== 2'b00) begin miscompares++; $display("FAIL mode_early got %b want 00", bus.mode); end
            end
            if (i == 7) begin
                vectors++; if (bus.mode !== 2'b01) begin miscompares++; $display("FAIL mode_latency got %b want 01", bus.mode); end
            end
            if (bus.mode !== prev) changes++;
            prev = bus.mode;
        end
        vectors++; if (bus.mode !== 2'b01) begin miscompares++; $display("FAIL long_press_mode got %b want 01", bus.mode); end
        vectors++; if (changes !== 1) begin miscompares++; $display("FAIL long_press_changes got %0d want 1", changes); end
        for (int i = 0; i < 16 && !found; i++) begin
            tick(1);
            if (bus.sec_pulse === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL set_pulse_seen got 0 want 1"); end
        for (int j = 1; j <= 8; j++) begin
            tick(1);
            vectors++; if (bus.blink !== (j <= 4)) begin miscompares++; $display("FAIL set_blink_%0d got %b want %b", j, bus.blink, (j <= 4)); end
        end
        vectors++; if (bus.sec_bcd !== 8'h05) begin miscompares++; $display("FAIL set_sec_frozen got %h want 05", bus.sec_bcd); end
    endtask

    task automatic test_set_fields();
        for (int i = 0; i < 25; i++) press_btn(1'b1, 10);
        vectors++; if (bus.hour_bcd !== 8'h01) begin miscompares++; $display("FAIL hour_25_inc got %h want 01", bus.hour_bcd); end
        vectors++; if (bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL hour_inc_min got %h want 00", bus.min_bcd); end
        press_btn(1'b0, 10);
        vectors++; if (bus.mode !== 2'b10) begin miscompares++; $display("FAIL to_set_min got %b want 10", bus.mode); end
        for (int i = 0; i < 61; i++) press_btn(1'b1, 10);
        vectors++; if (bus.min_bcd !== 8'h01) begin miscompares++; $display("FAIL min_61_inc got %h want 01", bus.min_bcd); end
        vectors++; if (bus.hour_bcd !== 8'h01) begin miscompares++; $display("FAIL min_inc_hour got %h want 01", bus.hour_bcd); end
    endtask

    task automatic test_exit_set();
        bit found = 1'b0;
        int first_pulse = -1;
        int blink_low = 0;
        bus.run_en   = 1'b1;
        bus.btn_mode = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (bus.mode === 2'b00) found = 1'b1;
        end
        bus.btn_mode = 1'b0;
        vectors++; if (!found) begin miscompares++; $display("FAIL exit_seen got 0 want 1"); end
        vectors++; if (bus.sec_bcd !== 8'h00) begin miscompares++; $display("FAIL exit_sec_clear got %h want 00", bus.sec_bcd); end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (bus.sec_pulse === 1'b1 && first_pulse < 0) first_pulse = k;
            if (bus.blink !== 1'b1) blink_low++;
        end
        vectors++; if (first_pulse !== 7) begin miscompares++; $display("FAIL exit_pulse_delay got %0d want 7", first_pulse); end
        vectors++; if (bus.sec_bcd !== 8'h01) begin miscompares++; $display("FAIL exit_first_sec got %h want 01", bus.sec_bcd); end
        vectors++; if (blink_low !== 0) begin miscompares++; $display("FAIL exit_blink_low got %0d want 0", blink_low); end
        bus.run_en = 1'b0;
        press_btn(1'b1, 10);
        vectors++; if (bus.min_bcd !== 8'h01 || bus.hour_bcd !== 8'h01 || bus.sec_bcd !== 8'h01) begin miscompares++; $display("FAIL run_inc_ignored got %h:%h:%h want 01:01:01", bus.hour_bcd, bus.min_bcd, bus.sec_bcd); end
    endtask

    task automatic test_midnight();
        bit found = 1'b0;
        apply_reset();
        bus.run_en = 1'b0;
        press_btn(1'b0, 10);
        for (int i = 0; i < 23; i++) press_btn(1'b1, 10);
        vectors++; if (bus.hour_bcd !== 8'h23) begin miscompares++; $display("FAIL preload_hour got %h want 23", bus.hour_bcd); end
        press_btn(1'b0, 10);
        for (int i = 0; i < 59; i++) press_btn(1'b1, 10);
        vectors++; if (bus.min_bcd !== 8'h59) begin miscompares++; $display("FAIL preload_min got %h want 59", bus.min_bcd); end
        bus.run_en   = 1'b1;
        bus.btn_mode = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (bus.mode === 2'b00) found = 1'b1;
        end
        bus.btn_mode = 1'b0;
        vectors++; if (!found) begin miscompares++; $display("FAIL midnight_exit got 0 want 1"); end
        tick(464);
        vectors++; if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h235958) begin miscompares++; $display("FAIL at_235958 got %h want 235958", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}); end
        tick(15);
        vectors++; if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h235959) begin miscompares++; $display("FAIL at_235959 got %h want 235959", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}); end
        tick(1);
        vectors++; if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h000000) begin miscompares++; $display("FAIL midnight_wrap got %h want 000000", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}); end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        apply_reset();
        bus.run_en = 1'b0;
        press_btn(1'b0, 10);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        tick(10);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        tick(10);
        vectors++; if (bus.mode !== 2'b10) begin miscompares++; $display("FAIL both_mode got %b want 10", bus.mode); end
        vectors++; if (bus.hour_bcd !== 8'h00 || bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL both_inc_dropped got %h:%h want 00:00", bus.hour_bcd, bus.min_bcd); end
        for (int i = 0; i < 16 && !found; i++) begin
            tick(1);
            if (bus.sec_pulse === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL b2b_pulse_seen got 0 want 1"); end
        tick(2);
        bus.btn_inc = 1'b1;
        tick(6);
        vectors++; if (bus.sec_pulse !== 1'b1 || bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL inc_pulse_pre got pulse %b min %h want 1 00", bus.sec_pulse, bus.min_bcd); end
        tick(1);
        vectors++; if (bus.min_bcd !== 8'h01 || bus.sec_bcd !== 8'h00) begin miscompares++; $display("FAIL inc_with_pulse got %h:%h want 01:00", bus.min_bcd, bus.sec_bcd); end
        bus.btn_inc = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_pending();
        apply_reset();
        press_btn(1'b0, 10);
        press_btn(1'b0, 10);
        bus.btn_inc = 1'b1;
        tick(6);
        vectors++; if (bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL ctrl_min_early got %h want 00", bus.min_bcd); end
        tick(1);
        vectors++; if (bus.min_bcd !== 8'h01) begin miscompares++; $display("FAIL ctrl_min_inc got %h want 01", bus.min_bcd); end
        bus.btn_inc = 1'b0;
        tick(10);
        bus.btn_inc = 1'b1;
        tick(6);
        reset = 1'b1;
        tick(1);
        vectors++; if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h000000) begin miscompares++; $display("FAIL rst_pend_time got %h want 000000", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}); end
        vectors++; if (bus.mode !== 2'b00 || bus.blink !== 1'b1 || bus.sec_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_pend_ctrl got mode %b blink %b pulse %b want 00 1 0", bus.mode, bus.blink, bus.sec_pulse); end
        reset = 1'b0;
        bus.btn_inc = 1'b0;
        tick(10);
        vectors++; if (bus.min_bcd !== 8'h00 || bus.mode !== 2'b00) begin miscompares++; $display("FAIL rst_pend_after got min %h mode %b want 00 00", bus.min_bcd, bus.mode); end
    endtask

    initial begin
        test_reset();
        test_run_minute();
        test_debounce_mode();
        test_set_fields();
        test_exit_set();
        test_midnight();
        test_back_to_back();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
